// File: rtl/helen_debug_pkg.sv
// rtl/helen_debug_pkg.sv - shared state type, widths and IR encodings for the Nios II debug host driver
package helen_debug_pkg;

  localparam int DEBUG_DR_WIDTH = 38;
  localparam int DEBUG_IR_WIDTH = 2;

  localparam logic [DEBUG_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_TRACE     = 2'd1;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEBUG_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI
  } dbg_state_e;

  // Indicator vector order is {uir, cdr, sdr, udr, rti}; IDLE drives none.
  function automatic logic [4:0] state_ind(input dbg_state_e st);
    case (st)
      ST_UIR:  return 5'b10000;
      ST_CDR:  return 5'b01000;
      ST_SDR:  return 5'b00100;
      ST_UDR:  return 5'b00010;
      ST_RTI:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/helen_debug_tck_gen.sv
// rtl/helen_debug_tck_gen.sv - divides clk into tck (low half first) with rise/fall strobes
// Strobes are high in the clk cycle whose closing edge toggles tck.
module helen_debug_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_vji_tck,
  output logic o_tck_rise,
  output logic o_tck_fall
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_tc;

  assign w_tc = i_en && (r_cnt == CW'(TCK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_vji_tck  = r_tck;
  assign o_tck_rise = w_tc && !r_tck;
  assign o_tck_fall = w_tc && r_tck;

endmodule

// File: rtl/helen_nios_cpu_debug_host_driver.sv
// rtl/helen_nios_cpu_debug_host_driver.sv - virtual-JTAG initiator for the Nios II debug slave
// Define HELEN_DEBUG_HOST_IR_SKIP_EN to skip UIR when the IR is unchanged.
module helen_nios_cpu_debug_host_driver
  import helen_debug_pkg::*;
#(
  parameter int DR_WIDTH = DEBUG_DR_WIDTH,
  parameter int IR_WIDTH = DEBUG_IR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = $clog2(DR_WIDTH);

  dbg_state_e          r_state;
  logic [4:0]          r_ind;
  logic [DR_WIDTH-1:0] r_tx_sr;
  logic [DR_WIDTH-1:0] r_rx_sr;
  logic [BW-1:0]       r_bit_cnt;
  logic                r_tdi;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DR_WIDTH-1:0] r_rsp_data;
  logic [IR_WIDTH-1:0] r_rsp_ir_out;

  logic w_tck_en;
  logic w_tck_rise;
  logic w_tck_fall;
  logic w_accept;
  logic w_skip_uir;

  assign w_tck_en = (r_state != ST_IDLE);
  assign w_accept = cmd_valid && r_cmd_ready;

  helen_debug_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (w_tck_en),
    .o_vji_tck (vji_tck),
    .o_tck_rise(w_tck_rise),
    .o_tck_fall(w_tck_fall)
  );

`ifdef HELEN_DEBUG_HOST_IR_SKIP_EN
  logic [IR_WIDTH-1:0] r_last_ir;
  logic                r_ir_valid;

  assign w_skip_uir = r_ir_valid && (cmd_ir == r_last_ir);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_ir  <= '0;
      r_ir_valid <= 1'b0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_last_ir  <= cmd_ir;
      r_ir_valid <= 1'b1;
    end
  end
`else
  assign w_skip_uir = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ind        <= '0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_bit_cnt    <= '0;
      r_tdi        <= 1'b0;
      r_ir_in      <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_ir_out <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ir_in     <= cmd_ir;
            r_tx_sr     <= cmd_data;
            r_tdi       <= cmd_data[0];
            r_bit_cnt   <= '0;
            r_cmd_ready <= 1'b0;
            if (w_skip_uir) begin
              r_state <= ST_CDR;
              r_ind   <= state_ind(ST_CDR);
            end else begin
              r_state <= ST_UIR;
              r_ind   <= state_ind(ST_UIR);
            end
          end
        end
        ST_UIR: begin
          if (w_tck_fall) begin
            r_state <= ST_CDR;
            r_ind   <= state_ind(ST_CDR);
          end
        end
        ST_CDR: begin
          if (w_tck_fall) begin
            r_state <= ST_SDR;
            r_ind   <= state_ind(ST_SDR);
          end
        end
        ST_SDR: begin
          if (w_tck_rise) begin
            r_rx_sr <= {vji_tdo, r_rx_sr[DR_WIDTH-1:1]};
          end
          if (w_tck_fall) begin
            r_tx_sr <= r_tx_sr >> 1;
            r_tdi   <= r_tx_sr[1];
            // Counter stops at the last bit so it never wraps mid-shift.
            if (r_bit_cnt == BW'(DR_WIDTH - 1)) begin
              r_state <= ST_UDR;
              r_ind   <= state_ind(ST_UDR);
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        ST_UDR: begin
          if (w_tck_rise) begin
            r_rsp_ir_out <= vji_ir_out;
          end
          if (w_tck_fall) begin
            r_state <= ST_RTI;
            r_ind   <= state_ind(ST_RTI);
          end
        end
        ST_RTI: begin
          if (w_tck_fall) begin
            r_state     <= ST_IDLE;
            r_ind       <= state_ind(ST_IDLE);
            r_rsp_data  <= r_rx_sr;
            r_rsp_valid <= 1'b1;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ind       <= '0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_ir_out = r_rsp_ir_out;
  assign vji_tdi    = r_tdi;
  assign vji_ir_in  = r_ir_in;
  assign vji_uir    = r_ind[4];
  assign vji_cdr    = r_ind[3];
  assign vji_sdr    = r_ind[2];
  assign vji_udr    = r_ind[1];
  assign vji_rti    = r_ind[0];

endmodule

// File: tb/tb_helen_nios_cpu_debug_host_driver.sv
// tb/tb_helen_nios_cpu_debug_host_driver.sv - scoreboard bench for the debug host driver
// Covers reset, loopback, busy, mid-op reset, IR skip and a TCK_DIV=1/DR_WIDTH=8 build.
module tb_helen_nios_cpu_debug_host_driver;

`ifdef HELEN_DEBUG_HOST_IR_SKIP_EN
  localparam int SKIP_LAT = 329;
  localparam int SKIP_UIR = 0;
`else
  localparam int SKIP_LAT = 337;
  localparam int SKIP_UIR = 8;
`endif

  typedef struct {
    logic [37:0] data;
    logic [1:0]  ir_out;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        rsp_valid;
  logic [37:0] rsp_data;
  logic [1:0]  rsp_ir_out;
  logic        vji_tck, vji_tdi, vji_tdo;
  logic [1:0]  vji_ir_in, vji_ir_out;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  logic        cmd_valid_8;
  logic        cmd_ready_8;
  logic [1:0]  cmd_ir_8;
  logic [7:0]  cmd_data_8;
  logic        rsp_valid_8;
  logic [7:0]  rsp_data_8;
  logic [1:0]  rsp_ir_out_8;
  logic        vji_tck_8, vji_tdi_8;
  logic        vji_tdo_8;
  logic [1:0]  vji_ir_in_8, vji_ir_out_8;
  logic        vji_uir_8, vji_cdr_8, vji_sdr_8, vji_udr_8, vji_rti_8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int rsp_count = 0;
  int sdr_cycles = 0;
  int uir_cycles = 0;
  exp_t sb[$];

  logic        model_load;
  logic [37:0] model_load_val;
  logic [37:0] model;
  logic [37:0] model_pred;
  logic        tck_q;

  logic [7:0]  tdi_log_8;
  int          tdi_n_8 = 0;

  always #5 clk = ~clk;

  helen_nios_cpu_debug_host_driver u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  helen_nios_cpu_debug_host_driver #(.DR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1)) u_dut_8 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_8), .cmd_ready(cmd_ready_8), .cmd_ir(cmd_ir_8), .cmd_data(cmd_data_8),
    .rsp_valid(rsp_valid_8), .rsp_data(rsp_data_8), .rsp_ir_out(rsp_ir_out_8),
    .vji_tck(vji_tck_8), .vji_tdi(vji_tdi_8), .vji_tdo(vji_tdo_8),
    .vji_ir_in(vji_ir_in_8), .vji_ir_out(vji_ir_out_8),
    .vji_uir(vji_uir_8), .vji_cdr(vji_cdr_8), .vji_sdr(vji_sdr_8), .vji_udr(vji_udr_8), .vji_rti(vji_rti_8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: shifts tdi in at the MSB one clk after each SDR tck rise.
  always @(posedge clk) begin
    tck_q <= vji_tck;
    if (model_load) model <= model_load_val;
    else if (vji_tck && !tck_q && vji_sdr) model <= {vji_tdi, model[37:1]};
  end
  assign vji_tdo = model[0];

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;
    if (vji_sdr === 1'b1) sdr_cycles <= sdr_cycles + 1;
    if (vji_uir === 1'b1) uir_cycles <= uir_cycles + 1;
  end

  always @(posedge vji_tck_8) begin
    if (vji_sdr_8 && tdi_n_8 < 8) begin
      tdi_log_8[tdi_n_8] <= vji_tdi_8;
      tdi_n_8 <= tdi_n_8 + 1;
    end
  end

  task automatic load_model(input logic [37:0] val);
    model_load = 1'b1;
    model_load_val = val;
    model_pred = val;
    @(negedge clk);
    model_load = 1'b0;
  endtask

  task automatic send(input logic [1:0] ir, input logic [37:0] data, input int lat);
    exp_t e;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_ir = ir;
    cmd_data = data;
    vji_ir_out = ~ir;
    accept_cyc = cyc;
    e.data = model_pred;
    e.ir_out = ~ir;
    e.lat = lat;
    sb.push_back(e);
    model_pred = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    exp_t e;
    int n = 0;
    int lat;
    while (rsp_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_rsp: rsp_valid=%b queued=%0d, required a response", name, rsp_valid, sb.size());
      if (sb.size() != 0) e = sb.pop_front();
      return;
    end
    e = sb.pop_front();
    lat = cyc - accept_cyc;
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, e.lat);
    end
    checks++;
    if (rsp_data !== e.data) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, rsp_data, e.data);
    end
    checks++;
    if (rsp_ir_out !== e.ir_out) begin
      errors++;
      $display("FAIL %s_ir_out: got %b, required %b", name, rsp_ir_out, e.ir_out);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid} !== 8'b0 ||
        cmd_ready !== 1'b1 || vji_ir_in !== 2'b0 || rsp_data !== 38'b0 || rsp_ir_out !== 2'b0) begin
      errors++;
      $display("FAIL %s: tck=%b tdi=%b ind=%b%b%b%b%b rsp_valid=%b cmd_ready=%b ir_in=%b rsp_data=%h rsp_ir=%b, required all 0 and cmd_ready=1",
               name, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, rsp_valid,
               cmd_ready, vji_ir_in, rsp_data, rsp_ir_out);
    end
    checks++;
    if ({vji_tck_8, vji_tdi_8, vji_uir_8, vji_cdr_8, vji_sdr_8, vji_udr_8, vji_rti_8, rsp_valid_8} !== 8'b0 ||
        cmd_ready_8 !== 1'b1 || rsp_data_8 !== 8'b0) begin
      errors++;
      $display("FAIL %s_dr8: tck=%b sdr=%b rsp_valid=%b cmd_ready=%b rsp_data=%h, required idle reset values",
               name, vji_tck_8, vji_sdr_8, rsp_valid_8, cmd_ready_8, rsp_data_8);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_load = 1'b1;
    model_load_val = 38'h15_5555_5555;
    model_pred = 38'h15_5555_5555;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset_held");
    model_load = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_loopback();
    int sdr0;
    sdr0 = sdr_cycles;
    send(2'd2, 38'h3F_0F0F_0F0F, 337);
    wait_rsp("loopback");
    @(negedge clk);
    checks++;
    if (sdr_cycles - sdr0 != 304) begin
      errors++;
      $display("FAIL loopback_sdr_cycles: got %0d, required 304", sdr_cycles - sdr0);
    end
    checks++;
    if (model !== 38'h3F_0F0F_0F0F) begin
      errors++;
      $display("FAIL loopback_model: got %h, required %h", model, 38'h3F_0F0F_0F0F);
    end
  endtask

  task automatic test_busy();
    int rsp0;
    rsp0 = rsp_count;
    send(2'd0, 38'h01_2345_6789, 337);
    while (cyc < accept_cyc + 100) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || vji_ir_in !== 2'd0) begin
      errors++;
      $display("FAIL busy_ready: cmd_ready=%b ir_in=%b, required 0 and 00", cmd_ready, vji_ir_in);
    end
    cmd_valid = 1'b1;
    cmd_ir = 2'd3;
    cmd_data = 38'h2A_BCDE_F012;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("busy");
    repeat (400) @(negedge clk);
    checks++;
    if (rsp_count - rsp0 != 1) begin
      errors++;
      $display("FAIL busy_rsp_count: got %0d, required 1", rsp_count - rsp0);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int rsp0;
    send(2'd3, 38'h0A_5A5A_5A5A, 337);
    while (cyc < accept_cyc + 16 + 20 * 8 + 3) @(negedge clk);
    checks++;
    if (vji_sdr !== 1'b1 || vji_ir_in !== 2'd3) begin
      errors++;
      $display("FAIL midreset_in_sdr: sdr=%b ir_in=%b, required 1 and 11", vji_sdr, vji_ir_in);
    end
    rsp0 = rsp_count;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vji_tck !== 1'b0 || vji_sdr !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_held: tck=%b sdr=%b rsp_valid=%b cmd_ready=%b, required 0 0 0 1",
                 vji_tck, vji_sdr, rsp_valid, cmd_ready);
      end
      @(negedge clk);
    end
    reset_n = 1'b1;
    while (sb.size() != 0) e = sb.pop_front();
    load_model(38'h2A_AAAA_AAAA);
    repeat (400) @(negedge clk);
    checks++;
    if (rsp_count != rsp0) begin
      errors++;
      $display("FAIL midreset_no_rsp: got %0d responses, required 0", rsp_count - rsp0);
    end
    send(2'd2, 38'h12_3456_789A, 337);
    wait_rsp("after_reset");
    @(negedge clk);
    checks++;
    if (model !== 38'h12_3456_789A) begin
      errors++;
      $display("FAIL after_reset_model: got %h, required %h", model, 38'h12_3456_789A);
    end
  endtask

  task automatic test_back_to_back_ir_skip();
    int uir0;
    send(2'd1, 38'h00_FFFF_0000, 337);
    wait_rsp("skip_first");
    uir0 = uir_cycles;
    send(2'd1, 38'h33_CCCC_3333, SKIP_LAT);
    wait_rsp("skip_second");
    checks++;
    if (uir_cycles - uir0 != SKIP_UIR) begin
      errors++;
      $display("FAIL skip_uir_cycles: got %0d, required %0d", uir_cycles - uir0, SKIP_UIR);
    end
  endtask

  task automatic test_dr8_div1();
    int acc;
    int n = 0;
    logic [7:0] exp_tdi;
    exp_tdi = 8'hA5;
    cmd_valid_8 = 1'b1;
    cmd_ir_8 = 2'd2;
    cmd_data_8 = 8'hA5;
    acc = cyc;
    @(negedge clk);
    cmd_valid_8 = 1'b0;
    while (rsp_valid_8 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid_8 !== 1'b1) begin
      errors++;
      $display("FAIL dr8_rsp: rsp_valid=%b, required 1", rsp_valid_8);
      return;
    end
    checks++;
    if (cyc - acc != 25) begin
      errors++;
      $display("FAIL dr8_latency: got %0d, required 25", cyc - acc);
    end
    checks++;
    if (rsp_data_8 !== 8'hFF || rsp_ir_out_8 !== 2'b01) begin
      errors++;
      $display("FAIL dr8_data: got %h/%b, required ff/01", rsp_data_8, rsp_ir_out_8);
    end
    checks++;
    if (tdi_n_8 != 8 || tdi_log_8 !== exp_tdi) begin
      errors++;
      $display("FAIL dr8_tdi_seq: got %0d bits %b (bit0 first), required 8 bits %b", tdi_n_8, tdi_log_8, exp_tdi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir = 2'd0;
    cmd_data = '0;
    vji_ir_out = 2'd0;
    cmd_valid_8 = 1'b0;
    cmd_ir_8 = 2'd0;
    cmd_data_8 = '0;
    vji_ir_out_8 = 2'b01;
    vji_tdo_8 = 1'b1;
    model_load = 1'b0;
    model_load_val = '0;
    model_pred = '0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_busy();
    test_mid_reset();
    test_back_to_back_ir_skip();
    test_dr8_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
